// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: MEM->WB pipeline register for the five-stage MIPS core.
// Holds instruction, PC and write-back data under a valid/ready handshake.
// Supports flush and an optional two-entry skid mode.
// Decodes the register-file destination and write enable locally.
// Counts retired instructions (completed output handshakes).
//
// Parameters:
//   DATA_W  width of the write-back data path
//   SKID    0 = single entry, combinational in_ready
//           1 = head + skid entry, registered in_ready
//   CNT_W   width of the retire counter
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               squash every held entry this cycle
//   in_valid/in_ready   upstream (MEM) handshake
//   in_instr/in_pc/in_wd incoming instruction, PC, write-back data
//   out_valid/out_ready downstream (WB) handshake on the head entry
//   out_instr/out_pc/out_wd head entry contents
//   out_wa/out_we       decoded destination register and write enable
//   retired             number of completed output handshakes (wraps)
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int SKID   = 0,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_wd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_wd,
  output logic [4:0]        out_wa,
  output logic              out_we,
  output logic [CNT_W-1:0]  retired
);

  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [DATA_W-1:0] wd;
  } entry_t;

  entry_t             head_q, head_d;
  entry_t             skid_q, skid_d;
  entry_t             in_entry;
  logic               head_valid_q, head_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic               rdy_q, rdy_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               accept;
  logic               xfer;

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [4:0]         dest;
  logic               writes;

  assign in_entry = {in_instr, in_pc, in_wd};

  // In skid mode in_ready comes from a flop so out_ready never reaches it
  // combinationally; reset and flush still gate it immediately.
  assign in_ready = (SKID != 0) ? (rdy_q & ~reset & ~flush)
                                : (~reset & ~flush & (~head_valid_q | out_ready));

  assign accept = in_valid & in_ready;
  assign xfer   = head_valid_q & out_ready;

  // Next-state for the head/skid entries and the retire counter.
  // Flush wins over everything except the transfer count, which a
  // flush-cycle handshake still earns.
  always_comb begin
    head_d       = head_q;
    head_valid_d = head_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    retired_d    = xfer ? (retired_q + CNT_W'(1)) : retired_q;

    if (flush) begin
      head_d       = '0;
      head_valid_d = 1'b0;
      skid_d       = '0;
      skid_valid_d = 1'b0;
    end else if (SKID == 0) begin
      if (accept) begin
        head_d       = in_entry;
        head_valid_d = 1'b1;
      end else if (xfer) begin
        head_valid_d = 1'b0;
      end
    end else begin
      if (xfer) begin
        if (skid_valid_q) begin
          // in_ready was 0 here, so no incoming word competes for the skid
          head_d       = skid_q;
          skid_d       = '0;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          head_d       = in_entry;
        end else begin
          head_valid_d = 1'b0;
        end
      end else if (accept) begin
        if (head_valid_q) begin
          skid_d       = in_entry;
          skid_valid_d = 1'b1;
        end else begin
          head_d       = in_entry;
          head_valid_d = 1'b1;
        end
      end
    end

    // Ready tracks "skid empty" one cycle late, which gives the required
    // fall-after-fill and rise-after-drain behaviour.
    rdy_d = ~skid_valid_d;
  end

  // State registers; reset leaves the skid empty so ready is set again
  // in the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      head_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b1;
      retired_q    <= '0;
    end else begin
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= rdy_d;
      retired_q    <= retired_d;
    end
  end

  assign op    = head_q.instr[31:26];
  assign funct = head_q.instr[5:0];

  // Destination decode from the head instruction.
  always_comb begin
    dest   = 5'd0;
    writes = 1'b0;
    case (op)
      6'b000000: begin
        dest = head_q.instr[15:11];
        case (funct)
          6'b001000, 6'b011000, 6'b011001, 6'b011010,
          6'b011011, 6'b010001, 6'b010011: writes = 1'b0;
          default:                         writes = 1'b1;
        endcase
      end
      6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011,
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dest   = head_q.instr[20:16];
        writes = 1'b1;
      end
      6'b000011: begin
        dest   = 5'd31;
        writes = 1'b1;
      end
      default: begin
        dest   = 5'd0;
        writes = 1'b0;
      end
    endcase
  end

  assign out_valid = head_valid_q;
  assign out_instr = head_q.instr;
  assign out_pc    = head_q.pc;
  assign out_wd    = head_q.wd;
  assign out_wa    = dest;
  // $0 is hard-wired, so a write to it is suppressed here.
  assign out_we    = head_valid_q & writes & (dest != 5'd0);
  assign retired   = retired_q;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// tb_wb_pipe_reg: directed scoreboard bench for wb_pipe_reg.
// dut_a: single-entry register with a 4-bit retire counter.
// dut_b: skid-buffer variant with a 32-bit retire counter.
module tb_wb_pipe_reg;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        we;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_wd;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_we;
  logic [31:0] a_out_instr, a_out_pc, a_out_wd;
  logic [4:0]  a_out_wa;
  logic [3:0]  a_retired;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_we;
  logic [31:0] b_out_instr, b_out_pc, b_out_wd;
  logic [4:0]  b_out_wa;
  logic [31:0] b_retired;

  exp_t qa[$];
  exp_t qb[$];
  exp_t stim_q[$];

  int checks = 0;
  int errors = 0;

  wb_pipe_reg #(.DATA_W(32), .SKID(0), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_wd(in_wd),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_instr(a_out_instr), .out_pc(a_out_pc), .out_wd(a_out_wd),
    .out_wa(a_out_wa), .out_we(a_out_we), .retired(a_retired)
  );

  wb_pipe_reg #(.DATA_W(32), .SKID(1), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_wd(in_wd),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_instr(b_out_instr), .out_pc(b_out_pc), .out_wd(b_out_wd),
    .out_wa(b_out_wa), .out_we(b_out_we), .retired(b_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] wd, input logic [4:0] wa,
                              input logic we);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.wd    = wd;
    e.wa    = wa;
    e.we    = we;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input exp_t e);
    in_instr = e.instr;
    in_pc    = e.pc;
    in_wd    = e.wd;
  endtask

  task automatic checkA(input string tag, input bit pop);
    exp_t e;
    checks++;
    assert (qa.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s observed=empty_scoreboard expected=entry", tag);
    end
    if (qa.size() != 0) begin
      e = qa[0];
      if (pop) void'(qa.pop_front());
      checkOutput({tag, "_a_valid"}, 64'(a_out_valid), 64'(1'b1));
      checkOutput({tag, "_a_instr"}, 64'(a_out_instr), 64'(e.instr));
      checkOutput({tag, "_a_pc"},    64'(a_out_pc),    64'(e.pc));
      checkOutput({tag, "_a_wd"},    64'(a_out_wd),    64'(e.wd));
      checkOutput({tag, "_a_wa"},    64'(a_out_wa),    64'(e.wa));
      checkOutput({tag, "_a_we"},    64'(a_out_we),    64'(e.we));
    end
  endtask

  task automatic checkB(input string tag, input bit pop);
    exp_t e;
    checks++;
    assert (qb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s observed=empty_scoreboard expected=entry", tag);
    end
    if (qb.size() != 0) begin
      e = qb[0];
      if (pop) void'(qb.pop_front());
      checkOutput({tag, "_b_valid"}, 64'(b_out_valid), 64'(1'b1));
      checkOutput({tag, "_b_instr"}, 64'(b_out_instr), 64'(e.instr));
      checkOutput({tag, "_b_pc"},    64'(b_out_pc),    64'(e.pc));
      checkOutput({tag, "_b_wd"},    64'(b_out_wd),    64'(e.wd));
      checkOutput({tag, "_b_wa"},    64'(b_out_wa),    64'(e.wa));
      checkOutput({tag, "_b_we"},    64'(b_out_we),    64'(e.we));
    end
  endtask

  task automatic checkIdleA(input string tag, input logic [3:0] ret);
    checkOutput({tag, "_a_valid"},   64'(a_out_valid), 64'(1'b0));
    checkOutput({tag, "_a_instr"},   64'(a_out_instr), 64'(0));
    checkOutput({tag, "_a_pc"},      64'(a_out_pc),    64'(0));
    checkOutput({tag, "_a_wd"},      64'(a_out_wd),    64'(0));
    checkOutput({tag, "_a_wa"},      64'(a_out_wa),    64'(0));
    checkOutput({tag, "_a_we"},      64'(a_out_we),    64'(0));
    checkOutput({tag, "_a_retired"}, 64'(a_retired),   64'(ret));
  endtask

  task automatic checkIdleB(input string tag, input logic [31:0] ret);
    checkOutput({tag, "_b_valid"},   64'(b_out_valid), 64'(1'b0));
    checkOutput({tag, "_b_instr"},   64'(b_out_instr), 64'(0));
    checkOutput({tag, "_b_pc"},      64'(b_out_pc),    64'(0));
    checkOutput({tag, "_b_wd"},      64'(b_out_wd),    64'(0));
    checkOutput({tag, "_b_wa"},      64'(b_out_wa),    64'(0));
    checkOutput({tag, "_b_we"},      64'(b_out_we),    64'(0));
    checkOutput({tag, "_b_retired"}, 64'(b_retired),   64'(ret));
  endtask

  // Streams every entry of stim_q back-to-back with out_ready held high;
  // each word is expected at the output one cycle after it is driven.
  task automatic streamRun(input string tag, input bit use_a, input bit use_b);
    int n;
    n = stim_q.size();
    a_out_ready = use_a;
    b_out_ready = use_b;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        applyStimulus(stim_q[i]);
        a_in_valid = use_a;
        b_in_valid = use_b;
        if (use_a) qa.push_back(stim_q[i]);
        if (use_b) qb.push_back(stim_q[i]);
      end else begin
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < n && use_a) checkOutput({tag, "_a_in_ready"}, 64'(a_in_ready), 64'(1'b1));
      if (i < n && use_b) checkOutput({tag, "_b_in_ready"}, 64'(b_in_ready), 64'(1'b1));
      if (i > 0 && use_a) checkA(tag, 1'b1);
      if (i > 0 && use_b) checkB(tag, 1'b1);
      @(posedge clk);
      #1;
    end
    stim_q.delete();
  endtask

  initial begin
    exp_t w;
    reset       = 1'b1;
    flush       = 1'b0;
    in_instr    = '0;
    in_pc       = '0;
    in_wd       = '0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkIdleA("rst", 4'd0);
    checkIdleB("rst", 32'd0);
    checkOutput("rst_a_in_ready", 64'(a_in_ready), 64'(1'b0));
    checkOutput("rst_b_in_ready", 64'(b_in_ready), 64'(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rel_a_in_ready", 64'(a_in_ready), 64'(1'b1));
    checkOutput("rel_b_in_ready", 64'(b_in_ready), 64'(1'b1));
    @(posedge clk);
    #1;

    // Streaming: addu $3 / lw $5 / jal / ori $0 through both variants
    $display("[TB] streaming");
    stim_q.push_back(mk(32'h00221821, 32'h100, 32'h11111111, 5'd3,  1'b1));
    stim_q.push_back(mk(32'h8C850000, 32'h104, 32'h22222222, 5'd5,  1'b1));
    stim_q.push_back(mk(32'h0C000010, 32'h108, 32'h0000010C, 5'd31, 1'b1));
    stim_q.push_back(mk(32'h34000001, 32'h10C, 32'h00000001, 5'd0,  1'b0));
    streamRun("stream", 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("stream_a_done", 64'(a_out_valid), 64'(1'b0));
    checkOutput("stream_b_done", 64'(b_out_valid), 64'(1'b0));
    checkOutput("stream_a_retired", 64'(a_retired), 64'(4'd4));
    checkOutput("stream_b_retired", 64'(b_retired), 64'(32'd4));
    @(posedge clk);
    #1;

    // Stall on the skid variant: A held, B to skid, C refused until drain
    $display("[TB] skid stall");
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    w = mk(32'h240A0001, 32'h200, 32'hAAAA0000, 5'd10, 1'b1);
    applyStimulus(w);
    qb.push_back(w);
    @(negedge clk);
    checkOutput("stall_s0_ready", 64'(b_in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    w = mk(32'h240B0002, 32'h204, 32'hBBBB0000, 5'd11, 1'b1);
    applyStimulus(w);
    qb.push_back(w);
    @(negedge clk);
    checkOutput("stall_s1_ready", 64'(b_in_ready), 64'(1'b1));
    checkB("stall_s1_hold", 1'b0);
    @(posedge clk);
    #1;
    w = mk(32'h240C0003, 32'h208, 32'hCCCC0000, 5'd12, 1'b1);
    applyStimulus(w);
    @(negedge clk);
    checkOutput("stall_s2_ready", 64'(b_in_ready), 64'(1'b0));
    checkB("stall_s2_hold", 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("stall_s3_ready", 64'(b_in_ready), 64'(1'b0));
    checkB("stall_s3_hold", 1'b0);
    @(posedge clk);
    #1;
    b_out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_s4_ready", 64'(b_in_ready), 64'(1'b0));
    checkB("stall_out_a", 1'b1);
    @(posedge clk);
    #1;
    qb.push_back(w);
    @(negedge clk);
    checkOutput("stall_s5_ready", 64'(b_in_ready), 64'(1'b1));
    checkB("stall_out_b", 1'b1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    checkB("stall_out_c", 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("stall_done", 64'(b_out_valid), 64'(1'b0));
    checkOutput("stall_retired", 64'(b_retired), 64'(32'd7));
    checkOutput("stall_sb_empty", 64'(qb.size()), 64'(0));
    @(posedge clk);
    #1;

    // Decode corner cases on the single-entry variant
    $display("[TB] decode corners");
    stim_q.push_back(mk(32'h00222818, 32'h300, 32'h00000030, 5'd5, 1'b0));
    stim_q.push_back(mk(32'h00603011, 32'h304, 32'h00000031, 5'd6, 1'b0));
    stim_q.push_back(mk(32'h03E02008, 32'h308, 32'h00000032, 5'd4, 1'b0));
    stim_q.push_back(mk(32'hAC850004, 32'h30C, 32'h00000033, 5'd0, 1'b0));
    stim_q.push_back(mk(32'h10220008, 32'h310, 32'h00000034, 5'd0, 1'b0));
    stim_q.push_back(mk(32'h00000000, 32'h314, 32'h00000035, 5'd0, 1'b0));
    stim_q.push_back(mk(32'h01003809, 32'h318, 32'h0000031C, 5'd7, 1'b1));
    streamRun("decode", 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("decode_done", 64'(a_out_valid), 64'(1'b0));
    checkOutput("decode_retired", 64'(a_retired), 64'(4'd11));
    @(posedge clk);
    #1;

    // Flush with head and skid full and out_ready high on the flush cycle
    $display("[TB] flush");
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    w = mk(32'h8C8D0000, 32'h400, 32'hD0D0D0D0, 5'd13, 1'b1);
    applyStimulus(w);
    qb.push_back(w);
    @(negedge clk);
    checkOutput("flush_f0_ready", 64'(b_in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    w = mk(32'h8C8E0000, 32'h404, 32'hE0E0E0E0, 5'd14, 1'b1);
    applyStimulus(w);
    qb.push_back(w);
    @(negedge clk);
    checkOutput("flush_f1_ready", 64'(b_in_ready), 64'(1'b1));
    checkB("flush_f1_hold", 1'b0);
    @(posedge clk);
    #1;
    flush       = 1'b1;
    b_out_ready = 1'b1;
    applyStimulus(mk(32'h8C8F0000, 32'h408, 32'hF0F0F0F0, 5'd15, 1'b1));
    @(negedge clk);
    checkOutput("flush_b_in_ready", 64'(b_in_ready), 64'(1'b0));
    checkOutput("flush_a_in_ready", 64'(a_in_ready), 64'(1'b0));
    checkB("flush_head_out", 1'b1);
    @(posedge clk);
    #1;
    flush      = 1'b0;
    b_in_valid = 1'b0;
    qb.delete();
    @(negedge clk);
    checkIdleB("flush_after", 32'd8);
    checkOutput("flush_after_ready", 64'(b_in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("flush_skid_gone", 64'(b_out_valid), 64'(1'b0));
    @(posedge clk);
    #1;

    // Reset mid-stream with both skid-variant entries valid
    $display("[TB] reset mid-stream");
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    applyStimulus(mk(32'h24100005, 32'h500, 32'h55555555, 5'd16, 1'b1));
    @(posedge clk);
    #1;
    applyStimulus(mk(32'h24110006, 32'h504, 32'h66666666, 5'd17, 1'b1));
    @(negedge clk);
    checkOutput("rmid_r1_ready", 64'(b_in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    reset      = 1'b1;
    b_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rmid_b_in_ready", 64'(b_in_ready), 64'(1'b0));
    checkOutput("rmid_a_in_ready", 64'(a_in_ready), 64'(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    qb.delete();
    @(negedge clk);
    checkIdleB("rmid_after", 32'd0);
    checkIdleA("rmid_after", 4'd0);
    checkOutput("rmid_after_ready", 64'(b_in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rmid_still_empty", 64'(b_out_valid), 64'(1'b0));
    @(posedge clk);
    #1;

    // Counter wrap: 17 transfers through the 4-bit counter
    $display("[TB] counter wrap");
    for (int i = 0; i < 17; i++) begin
      logic [31:0] ins;
      logic [4:0]  rt;
      rt  = 5'(i);
      ins = 32'h24000000 | (32'(i) << 16) | 32'(i);
      stim_q.push_back(mk(ins, 32'h600 + 32'(4 * i), 32'h7000 + 32'(i), rt, rt != 5'd0));
    end
    streamRun("wrap", 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("wrap_done", 64'(a_out_valid), 64'(1'b0));
    checkOutput("wrap_retired", 64'(a_retired), 64'(4'd1));
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised MEM→WB pipeline register for the five-stage MIPS core, replacing the fixed always-load stage register. Carries instruction, PC and write-back data under a valid/ready handshake with stall, flush and an optional two-entry skid mode. Decodes the write-back destination register and write enable locally, with `$0` suppression. Also keeps a retired-instruction counter for the testbench and the CPI report.

## Interface
Parameters:
- `DATA_W`, 32: width of the write-back data path.
- `SKID`, 0: 0 = single-entry register with combinational ready; 1 = two-entry skid buffer with registered `in_ready`.
- `CNT_W`, 32: width of the retire counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream (MEM) entry valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of the instruction.
- `in_wd`  in  DATA_W  write-back data.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  WB consumes the head this cycle.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  head PC.
- `out_wd`  out  DATA_W  head write-back data.
- `out_wa`  out  5  decoded destination register.
- `out_we`  out  1  register-file write enable.
- `retired`  out  CNT_W  count of completed output handshakes.

## Operation
- Accept when `in_valid & in_ready`. Transfer when `out_valid & out_ready`.
- SKID=0: one entry. `in_ready = ~reset & ~flush & (~out_valid | out_ready)`. On accept the entry loads; on transfer with no accept, `out_valid` clears.
- SKID=1: a head entry plus a skid entry. `in_ready` is a flop: 1 when the skid is empty, gated by `~reset & ~flush`.
  - If an entry is accepted while the head is held (valid, not transferred), it goes to the skid.
  - On transfer, a full skid moves to the head; the incoming word then fills the skid only if `in_ready` was 1.
  - Order is strictly FIFO.
- Destination decode from `out_instr`, with op = [31:26] and funct = [5:0]:
  - op 0 (R-type) → `out_wa` = rd [15:11]. Writes except funct jr 001000, mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011. jalr 001001 writes rd.
  - Loads (lb 100000, lbu 100100, lh 100001, lhu 100101, lw 100011) and ALU-immediates (addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110, lui 001111) → `out_wa` = rt [20:16], write.
  - jal 000011 → `out_wa` = 31, write.
  - All other opcodes → `out_wa` = 0, no write.
  - `out_we = out_valid & write & (out_wa != 0)`.
- Flush: both entries are invalidated and their data zeroed. Flush has priority over accept; `in_ready` is 0 in a flush cycle, so nothing is accepted. A transfer in the flush cycle still counts as retired.
- `retired` increments by 1 per transfer and wraps modulo 2^CNT_W. Only reset clears it; flush does not.

## Timing
- Reset values: `out_valid` 0, `out_instr` 0, `out_pc` 0, `out_wd` 0, `out_wa` 0, `out_we` 0, `retired` 0, `in_ready` 0.
- `in_ready` returns to 1 in the first cycle after `reset` deasserts. Reset mid-operation discards all entries.
- Latency is one cycle, input accept to `out_valid`, in both modes.
- SKID=0: throughput 1/cycle; `out_ready` reaches `in_ready` combinationally.
- SKID=1: throughput 1/cycle with no combinational path from `out_ready` to `in_ready`.
  - The skid fills in the cycle the head stalls.
  - `in_ready` falls the cycle after the skid fills and rises the cycle after the skid drains.
- `out_wa` and `out_we` are combinational from the head registers and valid in the same cycle as `out_valid`.
- Flush asserted in cycle n: `out_valid` is 0 from cycle n+1.

## Test plan
- Streaming: `out_ready`=1, SKID=0, 4 back-to-back accepts (addu $3,$1,$2 / lw $5,0($4) / jal / ori $0,$0,1) → one output per cycle, 1 cycle late. Expect wa/we = 3/1, 5/1, 31/1, 0/0; `retired`=4.
- Stall, SKID=1: `out_ready`=0 for 3 cycles while 3 valid words arrive (A, B, C) → A held at head, B in skid, `in_ready` 0 from the 2nd stall cycle, C not accepted. Release → A, B, C emerged in order, no loss or duplication.
- Decode corner cases: mult, mthi, jr, sw, beq, and 0x00000000 → `out_we`=0 each. jalr $7,$8 → wa 7, we 1.
- Flush with head and skid full, `out_ready`=1 on the flush cycle → head counted (`retired`+1), `out_valid`=0 next cycle, skid entry discarded, `in_ready`=0 during flush.
- Reset mid-stream with both entries valid → next cycle: all outputs 0, `retired`=0. `in_ready`=1 one cycle after release.
- Counter wrap: CNT_W=4, 17 transfers → `retired`=1.
